// File: rtl/cpu_pkg.sv
// Shared types for the CPU data-memory responder.
// Holds the responder state encoding and the latency counter width.
package cpu_pkg;

  localparam int LATCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } mem_state_t;

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter with a zero flag.
// Saturates at zero instead of wrapping.
module latency_counter
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                enable,
  input  logic [LATCNT_W-1:0] value,
  output logic                zero
);

  logic [LATCNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_memory_responder.sv
// Data-port responder: one request at a time, fixed latency,
// internal synchronous RAM, one-cycle response and stall line.
module data_memory_responder
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDRWIDTH = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reqValid,
  input  logic                 reqWrite,
  input  logic [ADDRWIDTH-1:0] reqAddress,
  input  logic [WIDTH-1:0]     reqData,
  output logic                 reqReady,
  output logic                 respValid,
  output logic [WIDTH-1:0]     respData,
  output logic                 stall
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam bit SHORT = (LATENCY == 1);
  localparam logic [LATCNT_W-1:0] LOAD_VAL =
    LATCNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  mem_state_t state, next_state;

  logic                 lat_write;
  logic [ADDRWIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]     lat_data;

  logic                 op_write;
  logic [ADDRWIDTH-1:0] op_addr;
  logic [WIDTH-1:0]     op_data;

  logic accept, cnt_load, cnt_en, cnt_zero, finish;

  logic [WIDTH-1:0] ram [DEPTH];

  latency_counter u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load   (cnt_load),
    .enable (cnt_en),
    .value  (LOAD_VAL),
    .zero   (cnt_zero)
  );

  always_comb begin
    next_state = state;
    reqReady   = 1'b0;
    respValid  = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          accept     = 1'b1;
          cnt_load   = 1'b1;
          next_state = SHORT ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (cnt_zero) next_state = RESPOND;
      end
      RESPOND: begin
        stall      = 1'b1;
        respValid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // With single-cycle latency the request is serviced straight from the inputs
  assign op_write = (state == IDLE) ? reqWrite   : lat_write;
  assign op_addr  = (state == IDLE) ? reqAddress : lat_addr;
  assign op_data  = (state == IDLE) ? reqData    : lat_data;
  assign finish   = !reset && (next_state == RESPOND)
                  && (state != RESPOND);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      respData  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_write <= reqWrite;
        lat_addr  <= reqAddress;
        lat_data  <= reqData;
      end
      if (finish) begin
        respData <= op_write ? op_data : ram[op_addr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (finish && op_write) begin
      ram[op_addr] <= op_data;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder.
// Latency-2 and latency-1 builds share the request inputs.
module tb_data_memory_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       reqValid;
  logic       reqWrite;
  logic [7:0] reqAddress;
  logic [7:0] reqData;

  logic       reqReady0, respValid0, stall0;
  logic [7:0] respData0;
  logic       reqReady1, respValid1, stall1;
  logic [7:0] respData1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_memory_responder #(
    .WIDTH(8), .ADDRWIDTH(8), .LATENCY(2)
  ) dut0 (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqWrite   (reqWrite),
    .reqAddress (reqAddress),
    .reqData    (reqData),
    .reqReady   (reqReady0),
    .respValid  (respValid0),
    .respData   (respData0),
    .stall      (stall0)
  );

  data_memory_responder #(
    .WIDTH(8), .ADDRWIDTH(8), .LATENCY(1)
  ) dut1 (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqWrite   (reqWrite),
    .reqAddress (reqAddress),
    .reqData    (reqData),
    .reqReady   (reqReady1),
    .respValid  (respValid1),
    .respData   (respData1),
    .stall      (stall1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives one request for a cycle, then waits (bounded) for the response.
  task automatic xact(
    input  bit         sel,
    input  logic       w,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] rd,
    output int         lat
  );
    reqValid   = 1'b1;
    reqWrite   = w;
    reqAddress = a;
    reqData    = d;
    tick();
    reqValid = 1'b0;
    lat = 1;
    while (!(sel ? respValid1 : respValid0) && lat < 20) begin
      tick();
      lat++;
    end
    rd = sel ? respData1 : respData0;
    tick();
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddress = 8'h01;
    reqData  = 8'hEE;
    tick();
    tick();
    reset    = 1'b0;
    reqValid = 1'b0;
    tick();
    checks++;
    if (reqReady0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", reqReady0);
    end
    checks++;
    if (stall0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", stall0);
    end
    checks++;
    if (respValid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", respValid0);
    end
    checks++;
    if (respData0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", respData0);
    end
    checks++;
    if (respData1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_data1 got %h want 00", respData1);
    end
  endtask

  task automatic test_store;
    reqValid   = 1'b1;
    reqWrite   = 1'b1;
    reqAddress = 8'h10;
    reqData    = 8'h5A;
    checks++;
    if (reqReady0 !== 1'b1) begin
      errors++;
      $display("FAIL st_t_ready got %b want 1", reqReady0);
    end
    tick();
    reqValid = 1'b0;
    checks++;
    if ({stall0, respValid0, reqReady0} !== 3'b100) begin
      errors++;
      $display("FAIL st_t1 stall/valid/ready got %b want 100",
               {stall0, respValid0, reqReady0});
    end
    tick();
    checks++;
    if ({stall0, respValid0, reqReady0} !== 3'b110) begin
      errors++;
      $display("FAIL st_t2 stall/valid/ready got %b want 110",
               {stall0, respValid0, reqReady0});
    end
    checks++;
    if (respData0 !== 8'h5A) begin
      errors++;
      $display("FAIL st_t2_data got %h want 5a", respData0);
    end
    tick();
    checks++;
    if ({stall0, respValid0, reqReady0} !== 3'b001) begin
      errors++;
      $display("FAIL st_t3 stall/valid/ready got %b want 001",
               {stall0, respValid0, reqReady0});
    end
    checks++;
    if (respData0 !== 8'h5A) begin
      errors++;
      $display("FAIL st_hold_data got %h want 5a", respData0);
    end
  endtask

  task automatic test_load;
    logic [7:0] rd;
    int lat;
    xact(1'b0, 1'b0, 8'h10, 8'h00, rd, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL ld_latency got %0d want 2", lat);
    end
    checks++;
    if (rd !== 8'h5A) begin
      errors++;
      $display("FAIL ld_data got %h want 5a", rd);
    end
    xact(1'b0, 1'b1, 8'h44, 8'h33, rd, lat);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    xact(1'b0, 1'b0, 8'h44, 8'hC3, rd, lat);
    checks++;
    if (rd !== 8'h33) begin
      errors++;
      $display("FAIL ld_after_reset got %h want 33", rd);
    end
    checks++;
    if (reqReady0 !== 1'b1) begin
      errors++;
      $display("FAIL ld_ready_back got %b want 1", reqReady0);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] vmask;
    logic [9:0] rmask;
    vmask = '0;
    rmask = '0;
    reqWrite   = 1'b0;
    reqAddress = 8'h10;
    reqData    = 8'h00;
    for (int k = 0; k < 10; k++) begin
      reqValid = (k < 8);
      vmask[k] = respValid0;
      rmask[k] = reqReady0;
      tick();
    end
    reqValid = 1'b0;
    checks++;
    if (vmask !== 10'h124) begin
      errors++;
      $display("FAIL b2b_valid got %b want %b", vmask, 10'h124);
    end
    checks++;
    if (rmask !== 10'h249) begin
      errors++;
      $display("FAIL b2b_ready got %b want %b", rmask, 10'h249);
    end
    checks++;
    if (respData0 !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_data got %h want 5a", respData0);
    end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] rd;
    int lat;
    xact(1'b0, 1'b1, 8'h20, 8'h11, rd, lat);
    reqValid   = 1'b1;
    reqWrite   = 1'b1;
    reqAddress = 8'h20;
    reqData    = 8'hFF;
    tick();
    reqValid = 1'b0;
    checks++;
    if (stall0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_stall got %b want 1", stall0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({respValid0, stall0} !== 2'b00) begin
      errors++;
      $display("FAIL mid_abort valid/stall got %b want 00",
               {respValid0, stall0});
    end
    tick();
    checks++;
    if (respValid0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resp got %b want 0", respValid0);
    end
    xact(1'b0, 1'b0, 8'h20, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'h11) begin
      errors++;
      $display("FAIL mid_old_value got %h want 11", rd);
    end
  endtask

  task automatic test_lat1;
    logic [7:0] rd;
    int lat;
    repeat (3) tick();
    xact(1'b1, 1'b1, 8'hFF, 8'hA7, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL l1_st_latency got %0d want 1", lat);
    end
    checks++;
    if (rd !== 8'hA7) begin
      errors++;
      $display("FAIL l1_st_echo got %h want a7", rd);
    end
    checks++;
    if ({reqReady1, stall1} !== 2'b10) begin
      errors++;
      $display("FAIL l1_ready_back ready/stall got %b want 10",
               {reqReady1, stall1});
    end
    xact(1'b1, 1'b0, 8'hFF, 8'h00, rd, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL l1_ld_latency got %0d want 1", lat);
    end
    checks++;
    if (rd !== 8'hA7) begin
      errors++;
      $display("FAIL l1_ld_data got %h want a7", rd);
    end
    repeat (3) tick();
  endtask

  initial begin
    reset      = 1'b1;
    reqValid   = 1'b0;
    reqWrite   = 1'b0;
    reqAddress = '0;
    reqData    = '0;
    #1;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_midflight();
    test_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
